// File: rtl/scr1_mprf_wb_pkg.sv
// Shared types and constants for the MPRF writeback arbiter.
// SCR1_RVE_EXT narrows the register address space to 16 entries.
package scr1_mprf_wb_pkg;

  localparam int unsigned SCR1_XLEN = 32;
  localparam int unsigned LANE      = 2;

`ifdef SCR1_RVE_EXT
  localparam int unsigned SCR1_MPRF_ADDR_WIDTH = 4;
`else
  localparam int unsigned SCR1_MPRF_ADDR_WIDTH = 5;
`endif

  // One pending bit per architectural register; bit 0 (x0) is tied low.
  localparam int unsigned SCR1_MPRF_WB_PEND_W = 2 ** SCR1_MPRF_ADDR_WIDTH;

  typedef logic [LANE*SCR1_XLEN-1:0]        type_vector;
  typedef logic [SCR1_MPRF_ADDR_WIDTH-1:0]  type_mprf_addr;

  typedef struct packed {
    type_mprf_addr addr;
    logic          is_vector;
    type_vector    data;
  } type_mprf_wb_entry;

  function automatic int unsigned SCR1_MPRF_WB_PTR_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/scr1_mprf_wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers carry an extra wrap bit
// so full and empty are told apart by the MSB compare.
module scr1_mprf_wb_fifo
  import scr1_mprf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  type_mprf_wb_entry push_data_i,
  input  logic              pop_i,
  output type_mprf_wb_entry head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = SCR1_MPRF_WB_PTR_W(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  type_mprf_wb_entry mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head_o  = mem[rd_ptr_q[IDX_W-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Payload storage carries no reset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/scr1_pipe_mprf_wb_arb.sv
// Arbitrates the single MPRF write port between EXU and VCP writeback and
// tracks in-flight VCP destinations. SCR1_MPRF_WB_BYPASS_EN enables the
// zero-latency path for VCP results when the FIFO is empty and EXU is idle.
module scr1_pipe_mprf_wb_arb
  import scr1_mprf_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exu_w_req,
  input  type_mprf_addr exu_rd_addr,
  input  logic          exu_rd_is_vector,
  input  type_vector    exu_rd_data,
  input  type_mprf_addr exu_rs1_addr,
  input  type_mprf_addr exu_rs2_addr,
  input  logic          exu_rs1_used,
  input  logic          exu_rs2_used,
  input  logic          exu_rd_used,
  output logic          exu_hazard,
  output logic          exu_wb_stall,
  input  logic          vcp_issue_vld,
  input  type_mprf_addr vcp_issue_rd,
  output logic          vcp_issue_rdy,
  input  logic          vcp_wb_vld,
  output logic          vcp_wb_rdy,
  input  type_mprf_addr vcp_wb_addr,
  input  logic          vcp_wb_is_vector,
  input  type_vector    vcp_wb_data,
  output logic          mprf_w_req,
  output type_mprf_addr mprf_rd_addr,
  output logic          mprf_rd_is_vector,
  output type_vector    mprf_rd_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  type_mprf_wb_entry              push_entry;
  type_mprf_wb_entry              head;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           fifo_push;
  logic                           head_grant;
  logic                           exu_win;
  logic                           bypass;
  logic                           clr_vld;
  type_mprf_addr                  clr_addr;
  logic [SCR1_MPRF_WB_PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]               starve_cnt_q, starve_cnt_d;
  logic                           force_q, force_d;

  assign push_entry = '{addr: vcp_wb_addr, is_vector: vcp_wb_is_vector, data: vcp_wb_data};

`ifdef SCR1_MPRF_WB_BYPASS_EN
  assign bypass = fifo_empty & ~exu_w_req & vcp_wb_vld;
`else
  assign bypass = 1'b0;
`endif

  assign exu_wb_stall = force_q & ~fifo_empty;
  assign head_grant   = ~fifo_empty & (force_q | ~exu_w_req);
  assign exu_win      = exu_w_req & ~exu_wb_stall;
  assign vcp_wb_rdy   = ~fifo_full;
  assign fifo_push    = vcp_wb_vld & vcp_wb_rdy & ~bypass;
  assign clr_vld      = head_grant | bypass;
  assign clr_addr     = head_grant ? head.addr : vcp_wb_addr;

  scr1_mprf_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (head_grant),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Write-port mux; an x0 destination still consumes its slot but never writes.
  always_comb begin
    mprf_w_req        = exu_win;
    mprf_rd_addr      = exu_rd_addr;
    mprf_rd_is_vector = exu_rd_is_vector;
    mprf_rd_data      = exu_rd_data;
    if (head_grant) begin
      mprf_w_req        = (head.addr != '0);
      mprf_rd_addr      = head.addr;
      mprf_rd_is_vector = head.is_vector;
      mprf_rd_data      = head.data;
    end else if (bypass) begin
      mprf_w_req        = (vcp_wb_addr != '0);
      mprf_rd_addr      = vcp_wb_addr;
      mprf_rd_is_vector = vcp_wb_is_vector;
      mprf_rd_data      = vcp_wb_data;
    end
  end

  assign vcp_issue_rdy = ~pend_q[vcp_issue_rd];
  assign exu_hazard    = (exu_rs1_used & pend_q[exu_rs1_addr]) |
                         (exu_rs2_used & pend_q[exu_rs2_addr]) |
                         (exu_rd_used  & pend_q[exu_rd_addr]);

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (clr_vld) pend_d[clr_addr] = 1'b0;
    if (vcp_issue_vld & vcp_issue_rdy & (vcp_issue_rd != '0)) pend_d[vcp_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    force_d      = 1'b0;
    if (fifo_empty | head_grant) begin
      starve_cnt_d = '0;
    end else if (exu_win) begin
      if (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
        starve_cnt_d = '0;
        force_d      = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      starve_cnt_q <= '0;
      force_q      <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      starve_cnt_q <= starve_cnt_d;
      force_q      <= force_d;
    end
  end

endmodule

// File: tb/tb_scr1_pipe_mprf_wb_arb.sv
// Directed bench for the MPRF writeback arbiter with an expected-write
// scoreboard drained by a monitor on every MPRF write.
module tb_scr1_pipe_mprf_wb_arb;
  import scr1_mprf_wb_pkg::*;

  localparam int unsigned EXP_W = SCR1_MPRF_ADDR_WIDTH + 1 + LANE*SCR1_XLEN;
`ifdef SCR1_MPRF_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          exu_w_req;
  type_mprf_addr exu_rd_addr;
  logic          exu_rd_is_vector;
  type_vector    exu_rd_data;
  type_mprf_addr exu_rs1_addr, exu_rs2_addr;
  logic          exu_rs1_used, exu_rs2_used, exu_rd_used;
  logic          exu_hazard, exu_wb_stall;
  logic          vcp_issue_vld;
  type_mprf_addr vcp_issue_rd;
  logic          vcp_issue_rdy;
  logic          vcp_wb_vld, vcp_wb_rdy;
  type_mprf_addr vcp_wb_addr;
  logic          vcp_wb_is_vector;
  type_vector    vcp_wb_data;
  logic          mprf_w_req;
  type_mprf_addr mprf_rd_addr;
  logic          mprf_rd_is_vector;
  type_vector    mprf_rd_data;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_exp;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scr1_pipe_mprf_wb_arb #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_w_req(exu_w_req), .exu_rd_addr(exu_rd_addr), .exu_rd_is_vector(exu_rd_is_vector),
    .exu_rd_data(exu_rd_data), .exu_rs1_addr(exu_rs1_addr), .exu_rs2_addr(exu_rs2_addr),
    .exu_rs1_used(exu_rs1_used), .exu_rs2_used(exu_rs2_used), .exu_rd_used(exu_rd_used),
    .exu_hazard(exu_hazard), .exu_wb_stall(exu_wb_stall),
    .vcp_issue_vld(vcp_issue_vld), .vcp_issue_rd(vcp_issue_rd), .vcp_issue_rdy(vcp_issue_rdy),
    .vcp_wb_vld(vcp_wb_vld), .vcp_wb_rdy(vcp_wb_rdy), .vcp_wb_addr(vcp_wb_addr),
    .vcp_wb_is_vector(vcp_wb_is_vector), .vcp_wb_data(vcp_wb_data),
    .mprf_w_req(mprf_w_req), .mprf_rd_addr(mprf_rd_addr),
    .mprf_rd_is_vector(mprf_rd_is_vector), .mprf_rd_data(mprf_rd_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expw(input type_mprf_addr a, input logic v, input type_vector d);
    exp_q.push_back({a, v, d});
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    exu_w_req = 0; exu_rd_addr = '0; exu_rd_is_vector = 0; exu_rd_data = '0;
    exu_rs1_addr = '0; exu_rs2_addr = '0;
    exu_rs1_used = 0; exu_rs2_used = 0; exu_rd_used = 0;
    vcp_issue_vld = 0; vcp_issue_rd = '0;
    vcp_wb_vld = 0; vcp_wb_addr = '0; vcp_wb_is_vector = 0; vcp_wb_data = '0;
  endtask

  // Monitor: every MPRF write must match the oldest expected write.
  always @(negedge clk) begin
    if (mprf_w_req === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL mprf_write: unexpected write addr=%0d data=%0h", mprf_rd_addr, mprf_rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mprf_rd_addr, mprf_rd_is_vector, mprf_rd_data} !== mon_exp) begin
          n_bad++;
          $display("FAIL mprf_write: got %0h, expected %0h",
                   {mprf_rd_addr, mprf_rd_is_vector, mprf_rd_data}, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_all();
    rst_n = 0;
    // Reset state; EXU write still passes straight through.
    exu_w_req = 1; exu_rd_addr = 5'd9; exu_rd_is_vector = 1; exu_rd_data = 64'hA5;
    exu_rs1_addr = 5'd5; exu_rs1_used = 1; vcp_issue_rd = 5'd5;
    expw(5'd9, 1'b1, 64'hA5);
    @(negedge clk);
    chk("rst_wb_rdy", vcp_wb_rdy, 1);
    chk("rst_issue_rdy", vcp_issue_rdy, 1);
    chk("rst_hazard", exu_hazard, 0);
    chk("rst_stall", exu_wb_stall, 0);
    chk("rst_w_req", mprf_w_req, 1);
    pedge();
    idle_all();
    pedge();
    rst_n = 1;
    pedge();

    // T1: pending source hazard and VCP writeback latency.
    vcp_issue_vld = 1; vcp_issue_rd = 5'd5;
    @(negedge clk); chk("t1_issue_rdy", vcp_issue_rdy, 1); chk("t1_hazard_pre", exu_hazard, 0);
    pedge();
    vcp_issue_vld = 0; exu_rs1_addr = 5'd5; exu_rs1_used = 1;
    vcp_wb_vld = 1; vcp_wb_addr = 5'd5; vcp_wb_data = 64'hD1;
    expw(5'd5, 1'b0, 64'hD1);
    @(negedge clk); chk("t1_hazard_rs1", exu_hazard, 1); chk("t1_w_req_now", mprf_w_req, BYP);
    pedge();
    vcp_wb_vld = 0;
    @(negedge clk); chk("t1_w_req_next", mprf_w_req, !BYP); chk("t1_hazard_next", exu_hazard, !BYP);
    pedge();
    @(negedge clk); chk("t1_hazard_clr", exu_hazard, 0);
    pedge();
    exu_rs1_used = 0;

    // T2: reissue to a pending rd is held off until its result is written.
    vcp_issue_vld = 1; vcp_issue_rd = 5'd7;
    @(negedge clk); chk("t2_issue_rdy1", vcp_issue_rdy, 1);
    pedge();
    exu_rd_addr = 5'd7; exu_rd_used = 1;
    @(negedge clk); chk("t2_issue_rdy2", vcp_issue_rdy, 0); chk("t2_hazard_rd", exu_hazard, 1);
    pedge();
    vcp_issue_vld = 0; exu_rd_used = 0;
    exu_rs2_addr = 5'd7; exu_rs2_used = 1; exu_rs1_addr = 5'd0; exu_rs1_used = 1;
    exu_w_req = 1; exu_rd_addr = 5'd10; exu_rd_data = 64'hE10; expw(5'd10, 1'b0, 64'hE10);
    vcp_wb_vld = 1; vcp_wb_addr = 5'd7; vcp_wb_data = 64'hD7; expw(5'd7, 1'b0, 64'hD7);
    @(negedge clk); chk("t2_hazard_rs2", exu_hazard, 1); chk("t2_wb_rdy", vcp_wb_rdy, 1);
    pedge();
    exu_w_req = 0; vcp_wb_vld = 0; vcp_issue_vld = 1;
    @(negedge clk); chk("t2_issue_rdy3", vcp_issue_rdy, 0); chk("t2_w_req", mprf_w_req, 1);
    pedge();
    @(negedge clk); chk("t2_issue_rdy4", vcp_issue_rdy, 1); chk("t2_hazard_clr", exu_hazard, 0);
    pedge();
    vcp_issue_vld = 0;
    @(negedge clk); chk("t2_hazard_again", exu_hazard, 1);
    pedge();
    exu_rs1_used = 0; exu_rs2_used = 0;

    // T3: starvation forces one FIFO write after STARVE_LIMIT EXU wins.
    exu_w_req = 1; exu_rd_addr = 5'd11; exu_rd_data = 64'hE0; expw(5'd11, 1'b0, 64'hE0);
    vcp_wb_vld = 1; vcp_wb_addr = 5'd12; vcp_wb_is_vector = 1; vcp_wb_data = 64'hC12;
    @(negedge clk); chk("t3_stall_a", exu_wb_stall, 0);
    pedge();
    vcp_wb_vld = 0;
    for (int i = 1; i <= 8; i++) begin
      exu_rd_data = 64'hE0 + 64'(i); expw(5'd11, 1'b0, 64'hE0 + 64'(i));
      @(negedge clk); chk("t3_stall_run", exu_wb_stall, 0);
      pedge();
    end
    exu_rd_data = 64'hE9; expw(5'd12, 1'b1, 64'hC12);
    @(negedge clk); chk("t3_stall_force", exu_wb_stall, 1);
    pedge();
    expw(5'd11, 1'b0, 64'hE9);
    vcp_wb_vld = 1; vcp_wb_addr = 5'd13; vcp_wb_is_vector = 0; vcp_wb_data = 64'hC13;
    @(negedge clk); chk("t3_stall_after", exu_wb_stall, 0);
    pedge();
    vcp_wb_vld = 0;
    for (int i = 0; i < 8; i++) begin
      exu_rd_data = 64'hF0 + 64'(i); expw(5'd11, 1'b0, 64'hF0 + 64'(i));
      @(negedge clk); chk("t3_stall_run2", exu_wb_stall, 0);
      pedge();
    end
    exu_rd_data = 64'hEF; expw(5'd13, 1'b0, 64'hC13);
    @(negedge clk); chk("t3_stall_force2", exu_wb_stall, 1);
    pedge();
    expw(5'd11, 1'b0, 64'hEF);
    @(negedge clk); chk("t3_stall_end", exu_wb_stall, 0);
    pedge();
    exu_w_req = 0;

    // T4: fill the FIFO behind a busy EXU, then drain in order.
    exu_w_req = 1; exu_rd_addr = 5'd14;
    for (int i = 0; i < 4; i++) begin
      exu_rd_data = 64'hB0 + 64'(i); expw(5'd14, 1'b0, 64'hB0 + 64'(i));
      vcp_wb_vld = 1; vcp_wb_addr = type_mprf_addr'(16 + i); vcp_wb_data = 64'hD0 + 64'(i);
      @(negedge clk); chk("t4_wb_rdy_fill", vcp_wb_rdy, 1);
      pedge();
    end
    exu_rd_data = 64'hB4; expw(5'd14, 1'b0, 64'hB4);
    vcp_wb_addr = 5'd20; vcp_wb_data = 64'hD4;
    @(negedge clk); chk("t4_wb_rdy_full", vcp_wb_rdy, 0);
    pedge();
    exu_w_req = 0; expw(5'd16, 1'b0, 64'hD0);
    @(negedge clk); chk("t4_wb_rdy_pop", vcp_wb_rdy, 0);
    pedge();
    expw(5'd17, 1'b0, 64'hD1);
    @(negedge clk); chk("t4_wb_rdy_back", vcp_wb_rdy, 1);
    pedge();
    vcp_wb_vld = 0;
    expw(5'd18, 1'b0, 64'hD2); @(negedge clk); chk("t4_drain3", mprf_w_req, 1); pedge();
    expw(5'd19, 1'b0, 64'hD3); @(negedge clk); chk("t4_drain4", mprf_w_req, 1); pedge();
    expw(5'd20, 1'b0, 64'hD4); @(negedge clk); chk("t4_drain5", mprf_w_req, 1); pedge();
    @(negedge clk); chk("t4_empty", mprf_w_req, 0);
    pedge();

    // T5: x0 results and issues leave no write and no pending bit.
    vcp_wb_vld = 1; vcp_wb_addr = 5'd0; vcp_wb_data = 64'hFF;
    vcp_issue_vld = 1; vcp_issue_rd = 5'd0;
    exu_rs1_addr = 5'd0; exu_rs1_used = 1; exu_rd_addr = 5'd0; exu_rd_used = 1;
    @(negedge clk); chk("t5_issue_x0", vcp_issue_rdy, 1); chk("t5_w_req_a", mprf_w_req, 0);
    pedge();
    vcp_wb_vld = 0;
    @(negedge clk); chk("t5_w_req_b", mprf_w_req, 0); chk("t5_issue_x0_b", vcp_issue_rdy, 1);
    chk("t5_hazard_x0", exu_hazard, 0);
    pedge();
    vcp_issue_vld = 0; exu_rs1_used = 0; exu_rd_used = 0;
    vcp_wb_vld = 1; vcp_wb_addr = 5'd3; vcp_wb_data = 64'h33; expw(5'd3, 1'b0, 64'h33);
    @(negedge clk); chk("t5_rd3_now", mprf_w_req, BYP);
    pedge();
    vcp_wb_vld = 0;
    @(negedge clk); chk("t5_rd3_next", mprf_w_req, !BYP);
    pedge();

    // T6: asynchronous reset mid-operation drops FIFO and pending state.
    vcp_issue_rd = 5'd7;
    @(negedge clk); chk("t6_pend_held", vcp_issue_rdy, 0);
    pedge();
    exu_w_req = 1; exu_rd_addr = 5'd22; exu_rd_data = 64'h22; expw(5'd22, 1'b0, 64'h22);
    vcp_wb_vld = 1; vcp_wb_addr = 5'd21; vcp_wb_data = 64'h21;
    pedge();
    exu_w_req = 0; vcp_wb_vld = 0;
    #2 rst_n = 0;
    @(negedge clk); chk("t6_pend_clr", vcp_issue_rdy, 1); chk("t6_w_req_rst", mprf_w_req, 0);
    chk("t6_wb_rdy", vcp_wb_rdy, 1);
    pedge();
    rst_n = 1;
    @(negedge clk); chk("t6_fifo_dropped", mprf_w_req, 0);
    pedge();
    pedge();

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
